operand_pair_buffer: RTL

OPERAND_PAIR_BUFFER -- requirements
Module: operand_pair_buffer

---
 rtl/operand_pair_buffer.sv | 126 ++++++++++++
 1 files changed

// File: rtl/operand_pair_buffer.sv
// -----------------------------------------------------------------------------
// operand_pair_buffer
//
// Holds a left operand (value to shift) and a right operand (shift amount) in
// two independent one-deep register slots. Each slot fills on its own
// valid/ready handshake. When both slots are full, the pair is presented
// downstream. A slot can be refilled on the same cycle that its pair is
// consumed, so the block sustains one pair per clock.
//
// Outputs come straight from the slot registers. outs_valid depends only on
// the full flags. The readies are the only signals that depend
// combinationally on outs_ready.
//
// Optional build macro:
//   OPERAND_PAIR_BUFFER_RHS_SATURATE_EN - when defined, rhs is clamped at
//   capture to DATA_TYPE-1 if its unsigned value is >= DATA_TYPE. lhs is
//   never modified.
//
// Ports:
//   clk        - clock; all state changes on the rising edge
//   rst        - synchronous active-high reset (clears flags and data)
//   lhs        - left operand,  lhs_valid / lhs_ready handshake
//   rhs        - right operand, rhs_valid / rhs_ready handshake
//   outs_lhs   - registered left operand of the presented pair
//   outs_rhs   - registered right operand of the presented pair
//   outs_valid - both slots full (pair presented)
//   outs_ready - downstream accepts the pair this cycle
// -----------------------------------------------------------------------------
module operand_pair_buffer #(
    parameter int DATA_TYPE = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_TYPE-1:0] lhs,
    input  logic                 lhs_valid,
    output logic                 lhs_ready,
    input  logic [DATA_TYPE-1:0] rhs,
    input  logic                 rhs_valid,
    output logic                 rhs_ready,
    output logic [DATA_TYPE-1:0] outs_lhs,
    output logic [DATA_TYPE-1:0] outs_rhs,
    output logic                 outs_valid,
    input  logic                 outs_ready
);

    // Slot 0 holds lhs and slot 1 holds rhs. Both slots use the same logic.
    // Only the value captured into each slot differs.
    logic                 fire;
    logic [1:0]           slot_full;
    logic [1:0]           slot_valid;
    logic [1:0]           slot_ready;
    logic [DATA_TYPE-1:0] slot_in   [2];
    logic [DATA_TYPE-1:0] slot_data [2];
    logic [DATA_TYPE-1:0] rhs_capture;

`ifdef OPERAND_PAIR_BUFFER_RHS_SATURATE_EN
    // This is the largest meaningful shift amount for a DATA_TYPE-wide value.
    localparam logic [DATA_TYPE-1:0] SHIFT_MAX = DATA_TYPE'(DATA_TYPE - 1);

    always_comb begin
        rhs_capture = rhs;
        if (rhs > SHIFT_MAX) begin
            rhs_capture = SHIFT_MAX;
        end
    end
`else
    assign rhs_capture = rhs;
`endif

    assign slot_in[0] = lhs;
    assign slot_in[1] = rhs_capture;
    assign slot_valid = {rhs_valid, lhs_valid};

    // These terms come from registers only, so outs_valid has no path from
    // outs_ready.
    assign outs_valid = &slot_full;
    assign fire       = outs_valid & outs_ready;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_slot
            logic                 full_reg;
            logic                 full_next;
            logic [DATA_TYPE-1:0] data_reg;
            logic [DATA_TYPE-1:0] data_next;
            logic                 accept;

            // A full slot can still accept data on the cycle its pair leaves.
            assign slot_ready[gi] = ~full_reg | fire;
            assign accept         = slot_valid[gi] & slot_ready[gi];

            // An accept takes priority over a release. Because of this, a
            // refill on a fire cycle keeps the slot full. A plain release
            // clears only the flag and leaves the data untouched.
            always_comb begin
                full_next = full_reg;
                data_next = data_reg;
                if (accept) begin
                    full_next = 1'b1;
                    data_next = slot_in[gi];
                end else if (fire) begin
                    full_next = 1'b0;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    full_reg <= 1'b0;
                    data_reg <= '0;
                end else begin
                    full_reg <= full_next;
                    data_reg <= data_next;
                end
            end

            assign slot_full[gi] = full_reg;
            assign slot_data[gi] = data_reg;
        end
    endgenerate

    assign lhs_ready = slot_ready[0];
    assign rhs_ready = slot_ready[1];
    assign outs_lhs  = slot_data[0];
    assign outs_rhs  = slot_data[1];

endmodule
